// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_muldiv_unit                                               |
// | Description : Multi-cycle multiply / multiply-accumulate / divide unit     |
// |               that sits beside the execute stage. It returns a 2*WIDTH     |
// |               {hi, lo} result for the HI/LO write path. For DIV/DIVU,      |
// |               hi holds the remainder and lo holds the quotient.            |
// |               The optional macro MULDIV_DIV_ZERO_FLAG_EN adds the          |
// |               div_zero_o output.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ex_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    ,
    output logic                 div_zero_o
`endif
);

    localparam int CNT_W = (WIDTH > 8) ? $clog2(WIDTH) : 3;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_mul  = 3'd1;
    localparam logic [2:0] c_st_acc  = 3'd2;
    localparam logic [2:0] c_st_div  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    // The MUL state lasts MUL_CYCLES-1 cycles; with a single-cycle multiply it is skipped
    localparam bit               c_mul_multi    = (MUL_CYCLES > 1);
    localparam logic [CNT_W-1:0] c_mul_cnt_init = CNT_W'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] c_div_cnt_init = CNT_W'(WIDTH - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_hilo;
    logic [2*WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_dz;
    logic                 r_dz_flag;

    // Two's-complement magnitude when the operand is treated as signed
    function automatic logic [WIDTH-1:0] f_abs(input logic sgn, input logic [WIDTH-1:0] x);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    // Decode of the incoming request and of the captured operation
    logic w_in_div, w_in_acc, w_in_dz, w_accept;
    logic w_is_div, w_is_acc, w_is_sub, w_signed;
    assign w_in_div = op_i[2] & op_i[1];
    assign w_in_acc = op_i[2] ^ op_i[1];
    assign w_in_dz  = w_in_div && (opdata2_i == '0);
    assign w_accept = (r_state == c_st_idle) && start_i && !annul_i;
    assign w_is_div = r_op[2] & r_op[1];
    assign w_is_acc = r_op[2] ^ r_op[1];
    assign w_is_sub = r_op[2] & ~r_op[1];
    assign w_signed = ~r_op[0];

    // Sign-magnitude multiply on the captured operands; held stable for the whole op
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0] w_prod_mag, w_prod;
    logic               w_neg_q, w_neg_r;
    assign w_mag_a    = f_abs(w_signed, r_a);
    assign w_mag_b    = f_abs(w_signed, r_b);
    assign w_prod_mag = (2*WIDTH)'(w_mag_a) * (2*WIDTH)'(w_mag_b);
    assign w_neg_q    = w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_neg_r    = w_signed && r_a[WIDTH-1];
    assign w_prod     = w_neg_q ? (~w_prod_mag + 1'b1) : w_prod_mag;

    // One restoring-division step: shift in the next dividend bit and trial-subtract
    logic [WIDTH+1:0] w_shift, w_trial;
    assign w_shift = {1'b0, r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {2'b00, w_mag_b};

    // Final {hi, lo} formed in the DONE cycle, including the divide sign fix
    logic [2*WIDTH-1:0] w_final;
    always_comb begin
        w_final = w_prod;
        if (r_dz) begin
            w_final = {r_a, {WIDTH{1'b1}}};
        end else if (w_is_div) begin
            w_final = {(w_neg_r ? (~r_rem + 1'b1) : r_rem),
                       (w_neg_q ? (~r_quo + 1'b1) : r_quo)};
        end else if (w_is_acc) begin
            w_final = r_work;
        end
    end

    assign busy_o = (r_state == c_st_mul) || (r_state == c_st_acc) || (r_state == c_st_div);
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    assign div_zero_o = r_dz_flag;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next;
    end

    // Next-state logic; a flush always wins and returns to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_in_div)         w_next = w_in_dz ? c_st_done : c_st_div;
                    else if (c_mul_multi) w_next = c_st_mul;
                    else                  w_next = w_in_acc ? c_st_acc : c_st_done;
                end
            end
            c_st_mul:  if (r_cnt == '0) w_next = w_is_acc ? c_st_acc : c_st_done;
            c_st_acc:  w_next = c_st_done;
            c_st_div:  if (r_cnt == '0) w_next = c_st_done;
            c_st_done: w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
        if (annul_i) w_next = c_st_idle;
    end

    // Operand capture, iteration datapath and result/ready registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_hilo    <= '0;
            r_work    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_dz      <= 1'b0;
            r_dz_flag <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            ready_o   <= 1'b0;
            r_dz_flag <= 1'b0;
            if (w_accept) begin
                r_op   <= op_i;
                r_a    <= opdata1_i;
                r_b    <= opdata2_i;
                r_hilo <= hilo_i;
                r_dz   <= w_in_dz;
                r_rem  <= '0;
                r_quo  <= f_abs(~op_i[0], opdata1_i);
                r_cnt  <= w_in_div ? c_div_cnt_init : c_mul_cnt_init;
            end else begin
                case (r_state)
                    c_st_mul: begin
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                    c_st_acc: begin
                        r_work <= w_is_sub ? (r_hilo - w_prod) : (r_hilo + w_prod);
                    end
                    c_st_div: begin
                        if (!w_trial[WIDTH+1]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                    c_st_done: begin
                        if (!annul_i) begin
                            result_o  <= w_final;
                            ready_o   <= 1'b1;
                            r_dz_flag <= r_dz;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_muldiv_unit                                            |
// | Description : Directed, table-driven bench for ex_muldiv_unit with         |
// |               hand-written sequences for flush, busy, chaining and reset.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ex_muldiv_unit;

    localparam int W  = 32;
    localparam int MC = 2;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2*W-1:0] hilo;
        logic [2*W-1:0] exp;
        int            n;
        bit            dz;
    } rec_t;

    logic           clk;
    logic           rst;
    logic           start_i;
    logic           annul_i;
    logic [2:0]     op_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic [2*W-1:0] hilo_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    logic           div_zero_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    rec_t vec[14];
    logic [2*W-1:0] last_res;

    ex_muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .hilo_i    (hilo_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
`ifdef MULDIV_DIV_ZERO_FLAG_EN
        ,
        .div_zero_o(div_zero_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input rec_t r);
        start_i   = 1'b1;
        op_i      = r.op;
        opdata1_i = r.a;
        opdata2_i = r.b;
        hilo_i    = r.hilo;
    endtask

    // Start must already be driven; the next rising edge is edge 0
    task automatic run_op(input string tag, input rec_t r, input bit poke, input bit chain, input rec_t nxt);
        int             seen;
        bit             busy_ok;
        logic [2*W-1:0] res;
        logic           dzv;
        seen    = -1;
        busy_ok = 1'b1;
        res     = '0;
        dzv     = 1'b0;
        @(posedge clk); #1;
        start_i   = 1'b0;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        hilo_i    = {$urandom, $urandom};
        for (int j = 0; j <= 40; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            if (poke && j == 3) begin
                start_i = 1'b1; op_i = 3'b000;
            end
            if (poke && j == 4) start_i = 1'b0;
            if (ready_o) begin
                seen = j;
                res  = result_o;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
                dzv  = div_zero_o;
`endif
                if (busy_o) busy_ok = 1'b0;
                if (chain) drive(nxt);
                break;
            end
            if (busy_o !== (j <= r.n - 2)) busy_ok = 1'b0;
        end
        chk({tag, " latency"}, 64'(seen), 64'(r.n));
        chk({tag, " result"}, res, r.exp);
        chk({tag, " busy pattern"}, 64'(busy_ok), 64'd1);
`ifdef MULDIV_DIV_ZERO_FLAG_EN
        chk({tag, " div_zero"}, 64'(dzv), 64'(r.dz));
`else
        if (dzv) chk({tag, " div_zero"}, 64'(dzv), 64'(r.dz));
`endif
        if (!chain) begin
            @(posedge clk); #1;
            chk({tag, " ready one-shot"}, 64'(ready_o), 64'd0);
        end
        last_res = r.exp;
    endtask

    initial begin
        rec_t blank;
        rec_t r_annul_div, r_mulu, r_poke;
        blank = '{3'b000, '0, '0, '0, '0, 0, 1'b0};
        //          op      a             b             hilo                    expected {hi,lo}         N   dz
        vec[0]  = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 64'h0,                  64'hFFFFFFFF_FFFFFFFA,  2, 1'b0};
        vec[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                  64'hFFFFFFFE_00000001,  2, 1'b0};
        vec[2]  = '{3'b000, 32'h80000000, 32'h80000000, 64'h0,                  64'h40000000_00000000,  2, 1'b0};
        vec[3]  = '{3'b011, 32'h00000001, 32'h00000001, 64'h00000000_FFFFFFFF,  64'h00000001_00000000,  3, 1'b0};
        vec[4]  = '{3'b100, 32'h00000002, 32'h00000003, 64'h0,                  64'hFFFFFFFF_FFFFFFFA,  3, 1'b0};
        vec[5]  = '{3'b010, 32'hFFFFFFFF, 32'h00000005, 64'h00000000_00000010,  64'h00000000_0000000B,  3, 1'b0};
        vec[6]  = '{3'b101, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_00000000,  64'hFFFFFFFF_00000002,  3, 1'b0};
        vec[7]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 64'h0,                  64'hFFFFFFFF_FFFFFFFD, 33, 1'b0};
        vec[8]  = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 64'h0,                  64'h80000000_00000000, 33, 1'b0};
        vec[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 64'h0,                  64'h00000000_80000000, 33, 1'b0};
        vec[10] = '{3'b111, 32'h00000005, 32'h00000000, 64'h0,                  64'h00000005_FFFFFFFF,  1, 1'b1};
        vec[11] = '{3'b110, 32'h00000064, 32'hFFFFFFF9, 64'h0,                  64'h00000002_FFFFFFF2, 33, 1'b0};
        vec[12] = '{3'b110, 32'hFFFFFF9C, 32'h00000000, 64'h0,                  64'hFFFFFF9C_FFFFFFFF,  1, 1'b1};
        vec[13] = '{3'b111, 32'h000003E8, 32'h0000000A, 64'h0,                  64'h00000000_00000064, 33, 1'b0};
        r_annul_div = '{3'b111, 32'h000003E8, 32'h00000007, 64'h0, 64'h0, 33, 1'b0};
        r_mulu      = '{3'b001, 32'h00000006, 32'h00000007, 64'h0, 64'h00000000_0000002A, 2, 1'b0};
        r_poke      = vec[13];
        last_res    = '0;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
        opdata1_i = '0; opdata2_i = '0; hilo_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset result_o", result_o, 64'h0);
        chk("reset ready_o", 64'(ready_o), 64'd0);
        chk("reset busy_o", 64'(busy_o), 64'd0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vec[i]);
            run_op($sformatf("vec%0d", i), vec[i], 1'b0, 1'b0, blank);
        end

        // start_i pulsed while a divide is busy must not disturb it
        @(negedge clk);
        drive(r_poke);
        run_op("busy-ignore", r_poke, 1'b1, 1'b0, blank);

        // back-to-back: the second op starts in the first op's ready cycle
        @(negedge clk);
        drive(vec[0]);
        run_op("chain0", vec[0], 1'b0, 1'b1, vec[3]);
        run_op("chain1", vec[3], 1'b0, 1'b0, blank);

        // annul in IDLE wins over a same-cycle start
        @(negedge clk);
        drive(vec[1]);
        annul_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        chk("annul-beats-start busy", 64'(busy_o), 64'd0);

        // flush a running divide at cycle 10, then a MULTU the cycle after
        @(negedge clk);
        drive(r_annul_div);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("annul busy drop", 64'(busy_o), 64'd0);
        chk("annul no ready", 64'(ready_o), 64'd0);
        chk("annul result held", result_o, last_res);
        drive(r_mulu);
        run_op("post-annul mulu", r_mulu, 1'b0, 1'b0, blank);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        drive(vec[7]);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst result_o", result_o, 64'h0);
        chk("async rst ready_o", 64'(ready_o), 64'd0);
        chk("async rst busy_o", 64'(busy_o), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        begin
            bit quiet;
            quiet = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (ready_o || busy_o) quiet = 1'b0;
            end
            chk("no ready after reset abort", 64'(quiet), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
